// File: rtl/day1_input_parser_if.sv
// day1_input_parser_if: byte stream into the parser and decoded instruction out of it.
interface day1_input_parser_if #(parameter int MAG_WIDTH = 16);
  logic [7:0]           byte_data;
  logic                 byte_valid;
  logic                 byte_last;
  logic                 byte_ready;
  logic                 direction;
  logic [MAG_WIDTH-1:0] magnitude;
  logic                 instruction_valid;
  logic                 instruction_ready;
  modport master (
    output byte_data, byte_valid, byte_last, instruction_ready,
    input  byte_ready, direction, magnitude, instruction_valid
  );
  modport slave (
    input  byte_data, byte_valid, byte_last, instruction_ready,
    output byte_ready, direction, magnitude, instruction_valid
  );
endinterface

// File: rtl/day1_input_parser.sv
// day1_input_parser: decodes "L68\nR48\n" style text into direction/magnitude instructions,
// with saturating magnitude, sticky parse error, handoff count and end-of-input done.
module day1_input_parser #(
  parameter int MAG_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   clear_n,
  day1_input_parser_if.slave     bus,
  output logic [COUNT_WIDTH-1:0] o_instruction_count,
  output logic                   o_parse_error,
  output logic                   o_done
);
  localparam logic [1:0] S_DIR  = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;
  localparam logic [MAG_WIDTH-1:0] MAG_MAX = '1;
  logic [1:0]           r_state;
  logic [MAG_WIDTH-1:0] r_acc;
  logic                 r_dig;
  logic                 r_pdir;
  logic                 r_dir;
  logic [MAG_WIDTH-1:0] r_mag;
  logic                 r_valid;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                 r_err;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_handoff;
  logic                 w_is_dir;
  logic                 w_is_digit;
  logic                 w_is_term;
  logic                 w_is_space;
  logic [MAG_WIDTH+3:0] w_prod;
  logic                 w_ovf;
  logic [1:0]           w_state_nx;
  logic [MAG_WIDTH-1:0] w_acc_nx;
  logic                 w_dig_nx;
  logic                 w_pdir_nx;
  logic                 w_err_set;
  logic                 w_emit;
  assign bus.byte_ready        = !r_done & (!r_valid | bus.instruction_ready);
  assign bus.direction         = r_dir;
  assign bus.magnitude         = r_mag;
  assign bus.instruction_valid = r_valid;
  assign o_instruction_count   = r_count;
  assign o_parse_error         = r_err;
  assign o_done                = r_done;
  assign w_accept   = bus.byte_valid & bus.byte_ready;
  assign w_handoff  = r_valid & bus.instruction_ready;
  assign w_is_dir   = (bus.byte_data == 8'h4C) | (bus.byte_data == 8'h52);
  assign w_is_digit = (bus.byte_data >= 8'h30) & (bus.byte_data <= 8'h39);
  assign w_is_term  = (bus.byte_data == 8'h0A) | (bus.byte_data == 8'h0D);
  assign w_is_space = bus.byte_data == 8'h20;
  // acc*10 + digit, four spare bits are enough to see any overflow
  assign w_prod = ({4'd0, r_acc} << 3) + ({4'd0, r_acc} << 1) + {{MAG_WIDTH{1'b0}}, bus.byte_data[3:0]};
  assign w_ovf  = |w_prod[MAG_WIDTH+3:MAG_WIDTH];
  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_dig_nx   = r_dig;
    w_pdir_nx  = r_pdir;
    w_err_set  = 1'b0;
    w_emit     = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_DIR: begin
          if (w_is_dir) begin
            w_pdir_nx  = bus.byte_data == 8'h52;
            w_acc_nx   = '0;
            w_dig_nx   = 1'b0;
            w_state_nx = S_NUM;
          end else if (!(w_is_term | w_is_space)) begin
            w_err_set  = 1'b1;
            w_state_nx = S_SKIP;
          end
        end
        S_NUM: begin
          if (w_is_digit) begin
            w_acc_nx  = w_ovf ? MAG_MAX : w_prod[MAG_WIDTH-1:0];
            w_err_set = w_ovf;
            w_dig_nx  = 1'b1;
          end else if (w_is_term) begin
            w_emit     = r_dig;
            w_err_set  = !r_dig;
            w_state_nx = S_DIR;
          end else begin
            w_err_set  = 1'b1;
            w_state_nx = S_SKIP;
          end
        end
        S_SKIP: w_state_nx = w_is_term ? S_DIR : S_SKIP;
        default: ;
      endcase
      // the final byte closes any open line as if a terminator had followed
      if (bus.byte_last && r_state != S_END) begin
        if (w_state_nx == S_NUM) begin
          w_emit    = w_emit | w_dig_nx;
          w_err_set = w_err_set | !w_dig_nx;
        end
        w_state_nx = S_END;
      end
    end
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_DIR;
      r_acc   <= '0;
      r_dig   <= 1'b0;
      r_pdir  <= 1'b0;
      r_dir   <= 1'b0;
      r_mag   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_acc   <= w_acc_nx;
      r_dig   <= w_dig_nx;
      r_pdir  <= w_pdir_nx;
      if (w_err_set) r_err <= 1'b1;
      if (w_emit) begin
        r_dir <= r_pdir;
        r_mag <= w_acc_nx;
      end
      r_valid <= w_emit | (r_valid & !bus.instruction_ready);
      if (w_handoff) r_count <= r_count + COUNT_WIDTH'(1);
      if (r_state == S_END && !(r_valid && !bus.instruction_ready)) r_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_day1_input_parser.sv
// tb_day1_input_parser: table vectors, hand-written corner sequences and random streams
// checked against a line-level reference model.
module tb_day1_input_parser;
  localparam int MW = 16;
  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] count;
  logic        perr;
  logic        done;
  day1_input_parser_if #(.MAG_WIDTH(MW)) bus();
  day1_input_parser #(.MAG_WIDTH(MW), .COUNT_WIDTH(32)) dut (
    .clock(clock), .clear_n(clear_n), .bus(bus),
    .o_instruction_count(count), .o_parse_error(perr), .o_done(done)
  );
  always #5 clock = ~clock;

  typedef struct {
    string s;
    bit    last;
    int    n;
    int    e0;
    int    e1;
    bit    err;
  } vec_t;

  int  errs = 0;
  int  checks = 0;
  int  got[$];
  int  exp_q[$];
  bit  exp_err;
  byte unsigned stim[$];
  vec_t tv[$];
  bit  rand_rdy = 1'b0;
  bit  fixed_rdy = 1'b1;
  bit  hold_p = 1'b0;
  int  hold_v;

  function automatic int ins(input int d, input int m);
    return d * 65536 + m;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock)
    bus.instruction_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;

  // records every handoff and checks the output register is frozen while stalled
  always @(negedge clock) begin
    #2;
    if (clear_n) begin
      if (hold_p) chk("hold_stable", {bus.instruction_valid, bus.direction, bus.magnitude}, hold_v);
      if (bus.instruction_valid && bus.instruction_ready) got.push_back({bus.direction, bus.magnitude});
      hold_p = bus.instruction_valid && !bus.instruction_ready;
      hold_v = {bus.instruction_valid, bus.direction, bus.magnitude};
    end else hold_p = 1'b0;
  end

  task automatic rst();
    clear_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_last = 1'b0;
    cyc();
    cyc();
    got.delete();
    clear_n = 1'b1;
    cyc();
  endtask

  task automatic send(input byte unsigned b, input bit l);
    int n = 0;
    bus.byte_data = b;
    bus.byte_valid = 1'b1;
    bus.byte_last = l;
    while (!bus.byte_ready && n < 500) begin
      cyc();
      n++;
    end
    chk("byte_ready_wait", bus.byte_ready, 1);
    cyc();
    bus.byte_valid = 1'b0;
    bus.byte_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit l);
    for (int i = 0; i < s.len(); i++) send(s[i], l && i == s.len() - 1);
  endtask

  task automatic addv(input string s, input bit l, input int n, input int e0, input int e1, input bit err);
    vec_t v;
    v.s = s; v.last = l; v.n = n; v.e0 = e0; v.e1 = e1; v.err = err;
    tv.push_back(v);
  endtask

  // one line of text: optional leading spaces, then L/R and one or more digits, nothing else
  task automatic eval_line(input byte unsigned ln[$]);
    int k = 0;
    int v = 0;
    bit sat = 1'b0;
    while (k < ln.size() && ln[k] == 8'h20) k++;
    if (k == ln.size()) return;
    if (ln[k] != 8'h4C && ln[k] != 8'h52) begin exp_err = 1'b1; return; end
    if (k + 1 == ln.size()) begin exp_err = 1'b1; return; end
    for (int j = k + 1; j < ln.size(); j++) begin
      if (ln[j] < 8'h30 || ln[j] > 8'h39) begin exp_err = 1'b1; return; end
      v = v * 10 + (ln[j] - 48);
      if (v > 65535) begin v = 65536; sat = 1'b1; end
    end
    if (sat) begin exp_err = 1'b1; v = 65535; end
    exp_q.push_back(ins(ln[k] == 8'h52, v));
  endtask

  task automatic model();
    byte unsigned ln[$];
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < stim.size(); i++) begin
      bit t = stim[i] == 8'h0A || stim[i] == 8'h0D;
      if (!t) ln.push_back(stim[i]);
      if (t || i == stim.size() - 1) begin
        eval_line(ln);
        ln.delete();
      end
    end
  endtask

  task automatic gen();
    int nl = $urandom_range(1, 8);
    stim.delete();
    for (int l = 0; l < nl; l++) begin
      string s;
      string d = $urandom_range(0, 1) ? "R" : "L";
      case ($urandom_range(0, 9))
        0, 1, 2, 3: s = {d, $sformatf("%0d", $urandom_range(0, 999))};
        4:          s = {d, $sformatf("%0d", $urandom_range(60000, 99999))};
        5:          s = "";
        6:          s = {" ", d, $sformatf("%0d", $urandom_range(0, 50))};
        7:          s = d;
        8:          s = {d, $sformatf("%0d", $urandom_range(0, 9)), "x"};
        default:    s = $sformatf("%c%0d", 8'($urandom_range(33, 126)), $urandom_range(0, 9));
      endcase
      if (!(l == nl - 1 && $urandom_range(0, 1))) begin
        if ($urandom_range(0, 2) == 0) s = {s, "\015\n"};
        else s = {s, "\n"};
      end
      for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    end
    if (stim.size() == 0) stim.push_back(8'h0A);
  endtask

  initial begin
    bus.byte_data = 8'h00;
    bus.byte_valid = 1'b0;
    bus.byte_last = 1'b0;
    addv("L68\nR48\n", 0, 2, ins(0, 68), ins(1, 48), 0);
    addv("R5\015\n\nL1000\015\n", 0, 2, ins(1, 5), ins(0, 1000), 0);
    addv("R70000\nL3\n", 0, 2, ins(1, 65535), ins(0, 3), 1);
    addv("X5\nL\nR7\n", 0, 1, ins(1, 7), 0, 1);
    addv(" L0\nR65535\n", 0, 2, ins(0, 0), ins(1, 65535), 0);
    addv("L12 \nR3 4\nRL5\n", 0, 0, 0, 0, 1);
    addv("L99", 1, 1, ins(0, 99), 0, 0);
    addv("\nR7\n", 1, 1, ins(1, 7), 0, 0);
    addv("R65536\n", 1, 1, ins(1, 65535), 0, 1);

    rst();
    chk("reset_valid", bus.instruction_valid, 0);
    chk("reset_dir", bus.direction, 0);
    chk("reset_mag", bus.magnitude, 0);
    chk("reset_count", count, 0);
    chk("reset_perr", perr, 0);
    chk("reset_done", done, 0);
    chk("reset_byte_ready", bus.byte_ready, 1);

    foreach (tv[v]) begin
      rst();
      send_str(tv[v].s, tv[v].last);
      repeat (4) cyc();
      chk($sformatf("vec%0d_n", v), got.size(), tv[v].n);
      if (tv[v].n > 0 && got.size() > 0) chk($sformatf("vec%0d_i0", v), got[0], tv[v].e0);
      if (tv[v].n > 1 && got.size() > 1) chk($sformatf("vec%0d_i1", v), got[1], tv[v].e1);
      chk($sformatf("vec%0d_count", v), count, tv[v].n);
      chk($sformatf("vec%0d_perr", v), perr, tv[v].err);
      chk($sformatf("vec%0d_done", v), done, tv[v].last);
    end

    rst();
    send_str("L68", 0);
    chk("lat_pre_valid", bus.instruction_valid, 0);
    send(8'h0A, 0);
    chk("lat_valid", bus.instruction_valid, 1);
    chk("lat_mag", bus.magnitude, 68);
    cyc();
    chk("lat_drop", bus.instruction_valid, 0);

    rst();
    send_str("L9", 0);
    send("9", 1);
    chk("last_valid", bus.instruction_valid, 1);
    chk("last_mag", bus.magnitude, 99);
    chk("last_done_early", done, 0);
    cyc();
    chk("last_done", done, 1);
    chk("last_byte_ready", bus.byte_ready, 0);
    bus.byte_data = "R";
    bus.byte_valid = 1'b1;
    repeat (3) cyc();
    bus.byte_data = 8'h0A;
    bus.byte_last = 1'b1;
    repeat (3) cyc();
    bus.byte_valid = 1'b0;
    bus.byte_last = 1'b0;
    chk("last_count", count, 1);
    chk("last_done_hold", done, 1);
    chk("last_no_valid", bus.instruction_valid, 0);

    rst();
    send_str("L1", 0);
    fixed_rdy = 1'b0;
    send(8'h0A, 0);
    bus.byte_data = "R";
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", bus.instruction_valid, 1);
      chk("bp_dir", bus.direction, 0);
      chk("bp_mag", bus.magnitude, 1);
      chk("bp_byte_ready", bus.byte_ready, 0);
      chk("bp_count", count, 0);
      cyc();
    end
    fixed_rdy = 1'b1;
    cyc();
    cyc();
    bus.byte_valid = 1'b0;
    send_str("2\n", 0);
    repeat (3) cyc();
    chk("bp_n", got.size(), 2);
    if (got.size() > 1) begin
      chk("bp_i0", got[0], ins(0, 1));
      chk("bp_i1", got[1], ins(1, 2));
    end
    chk("bp_count_end", count, 2);

    rst();
    send_str("X\nL5\nR1", 0);
    cyc();
    chk("ar_pre_perr", perr, 1);
    chk("ar_pre_count", count, 1);
    chk("ar_pre_mag", bus.magnitude, 5);
    #2;
    clear_n = 1'b0;
    #1;
    chk("ar_valid", bus.instruction_valid, 0);
    chk("ar_dir", bus.direction, 0);
    chk("ar_mag", bus.magnitude, 0);
    chk("ar_count", count, 0);
    chk("ar_perr", perr, 0);
    chk("ar_done", done, 0);
    cyc();
    got.delete();
    clear_n = 1'b1;
    cyc();
    send_str("L4\n", 0);
    repeat (3) cyc();
    chk("ar_n", got.size(), 1);
    if (got.size() > 0) chk("ar_i0", got[0], ins(0, 4));
    chk("ar_count_end", count, 1);
    chk("ar_perr_end", perr, 0);

    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int w = 0;
      rst();
      gen();
      model();
      for (int i = 0; i < stim.size(); i++) send(stim[i], i == stim.size() - 1);
      while (!done && w < 2000) begin
        cyc();
        w++;
      end
      chk("rand_done", done, 1);
      chk("rand_n", got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("rand_instr", got[i], exp_q[i]);
      chk("rand_count", count, exp_q.size());
      chk("rand_perr", perr, exp_err);
    end
    rand_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/day1_input_parser.md
Name:
day1_input_parser

Overview:
- Byte-stream decoder that turns raw Day 1 puzzle text (lines such as "L68", "R48") into the instruction stream the Day 1 dial solver consumes: direction, magnitude and instruction_valid.
- Sits between the host/UART byte source and the solver.
- Uses a valid/ready byte input and a registered instruction output with optional backpressure.
- Also reports an instruction count, a sticky parse error and end-of-input completion.

Parameters:
- MAG_WIDTH, 16, width of the magnitude output and accumulator; saturates at 2^MAG_WIDTH-1.
- COUNT_WIDTH, 32, width of instruction_count.

Ports:
- clock  input  1  sole clock; rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- byte_data  input  8  ASCII character.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_last  input  1  qualifies the final byte of the input; only meaningful with byte_valid.
- byte_ready  output  1  parser accepts a byte this cycle; a byte transfers when byte_valid & byte_ready.
- direction  output  1  1 = 'R', 0 = 'L'.
- magnitude  output  MAG_WIDTH  decoded decimal value.
- instruction_valid  output  1  direction/magnitude are valid.
- instruction_ready  input  1  consumer takes the instruction; tie high for the solver.
- instruction_count  output  COUNT_WIDTH  number of instructions handed off (valid & ready).
- parse_error  output  1  sticky malformed-input flag.
- done  output  1  sticky; set once the last byte is processed and the output register is empty.

Behaviour:
- Reset is decided: one clock; reset is asynchronous and active-low.
- clear_n low asynchronously clears all state. Reset values: direction=0, magnitude=0, instruction_valid=0, instruction_count=0, parse_error=0, done=0; FSM goes to S_DIR and the accumulator goes to 0.
- A partial line in progress at reset is discarded.
- byte_ready is combinational: byte_ready = !done & (!instruction_valid | instruction_ready). After reset it is 1.
- Character classes:
  - DIR: 'L' (0x4C) or 'R' (0x52).
  - DIGIT: 0x30-0x39.
  - TERM: '\n' (0x0A) or '\r' (0x0D).
  - SPACE: 0x20.
  - Anything else is OTHER.
- FSM (advances only on an accepted byte):
  - S_DIR: DIR latches the pending direction, clears the accumulator and digit flag, then goes to S_NUM. TERM or SPACE is skipped (blank lines and CRLF pairs are allowed). DIGIT or OTHER sets parse_error and goes to S_SKIP.
  - S_NUM: DIGIT sets acc = acc*10 + digit.
    - If the true result exceeds 2^MAG_WIDTH-1, acc saturates to all-ones and parse_error is set; parsing continues.
    - The digit flag is set.
    - TERM with the digit flag set emits and goes to S_DIR.
    - TERM without a digit sets parse_error, emits nothing and goes to S_DIR.
    - DIR, SPACE or OTHER sets parse_error, discards the line and goes to S_SKIP.
  - S_SKIP: all bytes are discarded until TERM, which returns to S_DIR.
- Emit: on the clock edge that accepts the terminating byte, the output register loads direction/magnitude and instruction_valid goes to 1.
  - Latency is one cycle from terminator acceptance to instruction_valid.
  - With instruction_ready=1, throughput is one instruction per byte cycle and no stall occurs.
- Output hold: while instruction_valid & !instruction_ready, direction, magnitude and instruction_valid are stable and byte_ready=0.
- Valid drop: instruction_valid clears on handoff unless a new emit happens in the same cycle. A new emit is possible because byte_ready is 1 when instruction_ready=1.
- instruction_count increments by 1 on each handoff and wraps modulo 2^COUNT_WIDTH.
- byte_last: the byte is first processed normally.
  - Then, if the FSM is in S_NUM with the digit flag set, the instruction emits that same edge as if a TERM had followed.
  - If it is in S_NUM without a digit, parse_error is set.
  - The FSM then enters S_END.
- S_END: once the output register is empty (no pending valid), done goes to 1 and remains 1 until reset. No further bytes are accepted.
- A TERM carried on byte_last emits exactly once, with no double emission.
- parse_error, once set, stays set until reset; it never blocks parsing of later lines.

Test Plan:
- Stream "L68\nR48\n", ready=1 -> two single-cycle valids, each one cycle after its '\n':
  - (0,68) then (1,48);
  - count=2, parse_error=0.
- Stream "R5\r\n\nL1000\r\n" -> exactly two instructions, (1,5) and (0,1000); blank line and CR skipped; parse_error=0.
- Stream "L99" with byte_last on '9', then more valid bytes -> (0,99) one cycle after last; done=1 next cycle; byte_ready=0 thereafter; count=1.
- Stream "R70000\nL3\n" -> (1,65535) with parse_error=1, then (0,3); count=2.
- Stream "X5\nL\nR7\n" -> only (1,7) is emitted; parse_error=1; count=1.
- instruction_ready held 0 for 4 cycles after the first emit of "L1\nR2\n" -> (0,1) is held stable, byte_ready=0 and '\n'… is not consumed; after ready rises, (1,2) follows. Assert clear_n low mid-"R12" -> all outputs return to 0 immediately; following "L4\n" yields (0,4).
